// File: rtl/traffic_controller_nphase.sv
// traffic_controller_nphase
//   N-phase intersection controller. Serves NUM_PHASES approaches in turn
//   through green, yellow and all-red clearance. It supports preset and
//   preferential green extension, a force-red override and a flashing-yellow
//   attention mode. Time advances only on cycles with tick=1, so one
//   instance can run from any timebase divider.
//
//   Optional build macro: TLC_DEMAND_SKIP_EN. When it is defined, the phase
//   served after clearance is the next phase (round-robin) with phase_req
//   set. When it is undefined, phases are served in strict round-robin order.
//
// Ports
//   clk           clock
//   rst           asynchronous reset, active-high
//   tick          timebase enable for all timers
//   preset        hold in PRESET (all red) before the first green
//   preset_add    each rising edge in PRESET adds EXTEND_STEP of green
//   preferential  sampled in INIT; starts extra green at EXTEND_STEP
//   force_red     level; all phases red while high
//   attention     level; requests flashing-yellow mode
//   phase_req     per-phase demand (TLC_DEMAND_SKIP_EN only)
//   lights        phase p lamps at [3p+2:3p] = {green,yellow,red}
//   active_phase  phase currently served
//   phase_done    one-cycle pulse when a phase's yellow completes
module traffic_controller_nphase #(
    parameter int NUM_PHASES  = 2,
    parameter int TIMER_W     = 8,
    parameter int GREEN_TIME  = 30,
    parameter int YELLOW_TIME = 3,
    parameter int ALLRED_TIME = 2,
    parameter int EXTEND_STEP = 10,
    parameter int FLASH_HALF  = 1,
    localparam int AW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic                    preset,
    input  logic                    preset_add,
    input  logic                    preferential,
    input  logic                    force_red,
    input  logic                    attention,
    input  logic [NUM_PHASES-1:0]   phase_req,
    output logic [3*NUM_PHASES-1:0] lights,
    output logic [AW-1:0]           active_phase,
    output logic                    phase_done
);

    typedef enum logic [2:0] {
        S_INIT,
        S_PRESET,
        S_GREEN,
        S_YELLOW,
        S_ALLRED,
        S_FLASH,
        S_FORCED
    } state_t;

    // Extra green saturates so that GREEN_TIME + extra still fits the timer.
    localparam int EXTRA_MAX = (1 << TIMER_W) - 1 - GREEN_TIME;
    localparam logic [TIMER_W-1:0] EXTRA_MAX_T = TIMER_W'(EXTRA_MAX);
    localparam logic [TIMER_W-1:0] STEP_T      = TIMER_W'(EXTEND_STEP);
    localparam logic [TIMER_W-1:0] PREF_INIT   =
        (EXTEND_STEP > EXTRA_MAX) ? EXTRA_MAX_T : STEP_T;

    localparam logic [TIMER_W:0] GREEN_D  = (TIMER_W+1)'(GREEN_TIME);
    localparam logic [TIMER_W:0] YELLOW_D = (TIMER_W+1)'(YELLOW_TIME);
    localparam logic [TIMER_W:0] ALLRED_D = (TIMER_W+1)'(ALLRED_TIME);
    localparam logic [TIMER_W:0] FLASH_D  = (TIMER_W+1)'(FLASH_HALF);

    localparam logic [AW-1:0] LAST_PHASE = AW'(NUM_PHASES - 1);

    state_t                    r_state;
    state_t                    w_state_n;
    logic [TIMER_W-1:0]        r_timer;
    logic [TIMER_W-1:0]        r_extra;
    logic                      r_flash;
    logic                      w_flash_n;
    logic                      r_add_d;
    logic                      w_add_rise;
    logic [AW-1:0]             r_phase;
    logic [AW-1:0]             w_phase_n;
    logic                      r_done;
    logic                      w_done_n;
    logic [3*NUM_PHASES-1:0]   r_lights;
    logic [TIMER_W:0]          w_dur;
    logic [TIMER_W:0]          w_dur_m1;
    logic                      w_expire;

`ifndef TLC_DEMAND_SKIP_EN
    logic w_unused_req;
    assign w_unused_req = ^phase_req;
`endif

    assign lights       = r_lights;
    assign active_phase = r_phase;
    assign phase_done   = r_done;

    // Phase served after clearance.
    function automatic logic [AW-1:0] next_phase(input logic [AW-1:0]         cur,
                                                 input logic [NUM_PHASES-1:0] req);
        logic [AW-1:0] nxt;
        nxt = (cur == LAST_PHASE) ? '0 : cur + 1'b1;
`ifdef TLC_DEMAND_SKIP_EN
        // Scan distances from farthest to nearest so that the nearest
        // requester wins. Distance NUM_PHASES is the current phase itself,
        // so it is picked only when no other phase is requesting.
        for (int unsigned k = NUM_PHASES; k >= 1; k--) begin
            logic [AW-1:0] cand;
            cand = AW'((int unsigned'(cur) + k) % NUM_PHASES);
            if (req[cand]) begin
                nxt = cand;
            end
        end
`else
        if (req != req) begin
            nxt = cur;
        end
`endif
        return nxt;
    endfunction

    // Lamp pattern presented while in state st.
    function automatic logic [3*NUM_PHASES-1:0] lamps(input state_t        st,
                                                      input logic [AW-1:0] ph,
                                                      input logic          fl);
        logic [3*NUM_PHASES-1:0] v;
        v = '0;
        for (int unsigned p = 0; p < NUM_PHASES; p++) begin
            case (st)
                S_GREEN:  v[3*p +: 3] = (AW'(p) == ph) ? 3'b100 : 3'b001;
                S_YELLOW: v[3*p +: 3] = (AW'(p) == ph) ? 3'b010 : 3'b001;
                S_FLASH:  v[3*p +: 3] = fl ? 3'b010 : 3'b000;
                default:  v[3*p +: 3] = 3'b001;
            endcase
        end
        return v;
    endfunction

    // Duration of the current state. A duration of 0 behaves as 1.
    always_comb begin
        case (r_state)
            S_GREEN:  w_dur = GREEN_D + {1'b0, r_extra};
            S_YELLOW: w_dur = YELLOW_D;
            S_ALLRED: w_dur = ALLRED_D;
            S_FLASH:  w_dur = FLASH_D;
            default:  w_dur = '0;
        endcase
        w_dur_m1 = (w_dur == '0) ? '0 : w_dur - 1'b1;
        w_expire = tick && ({1'b0, r_timer} == w_dur_m1);
    end

    assign w_add_rise = preset_add & ~r_add_d;

    // Next state. Priority: force_red, then attention, then timer expiry.
    always_comb begin
        w_state_n = r_state;
        w_phase_n = r_phase;
        w_flash_n = r_flash;
        w_done_n  = 1'b0;
        case (r_state)
            S_INIT: begin
                w_phase_n = '0;
                w_state_n = preset ? S_PRESET : S_GREEN;
            end
            S_PRESET: begin
                if (!preset) begin
                    w_state_n = S_GREEN;
                    w_phase_n = '0;
                end
            end
            S_GREEN: begin
                if (force_red) begin
                    w_state_n = S_FORCED;
                end else if (attention || w_expire) begin
                    w_state_n = S_YELLOW;
                end
            end
            S_YELLOW: begin
                if (force_red) begin
                    w_state_n = S_FORCED;
                end else if (w_expire) begin
                    w_done_n  = 1'b1;
                    w_state_n = attention ? S_FLASH : S_ALLRED;
                end
            end
            S_ALLRED: begin
                if (force_red) begin
                    w_state_n = S_FORCED;
                end else if (attention) begin
                    w_state_n = S_FLASH;
                end else if (w_expire) begin
                    w_state_n = S_GREEN;
                    w_phase_n = next_phase(r_phase, phase_req);
                end
            end
            S_FLASH: begin
                if (force_red) begin
                    w_state_n = S_FORCED;
                end else if (!attention) begin
                    w_state_n = S_ALLRED;
                end else if (w_expire) begin
                    w_flash_n = ~r_flash;
                end
            end
            S_FORCED: begin
                if (!force_red) begin
                    w_state_n = S_ALLRED;
                end
            end
            default: begin
                w_state_n = S_INIT;
            end
        endcase
        // Flashing always starts in the lit half-period.
        if (w_state_n == S_FLASH && r_state != S_FLASH) begin
            w_flash_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_INIT;
            r_timer  <= '0;
            r_extra  <= '0;
            r_flash  <= 1'b0;
            r_add_d  <= 1'b0;
            r_phase  <= '0;
            r_done   <= 1'b0;
            r_lights <= {NUM_PHASES{3'b001}};
        end else begin
            r_state  <= w_state_n;
            r_phase  <= w_phase_n;
            r_flash  <= w_flash_n;
            r_done   <= w_done_n;
            r_add_d  <= preset_add;
            r_lights <= lamps(w_state_n, w_phase_n, w_flash_n);

            // Timer restarts on every state entry; FLASH reuses it for each
            // half-period. Other timed states leave on expiry, so the
            // increment never runs past the duration.
            if (w_state_n != r_state) begin
                r_timer <= '0;
            end else if (r_state == S_FLASH && w_expire) begin
                r_timer <= '0;
            end else if (tick && (r_state == S_GREEN || r_state == S_YELLOW ||
                                  r_state == S_ALLRED || r_state == S_FLASH)) begin
                r_timer <= r_timer + 1'b1;
            end

            if (r_state == S_INIT) begin
                r_extra <= preferential ? PREF_INIT : '0;
            end else if (r_state == S_PRESET && w_add_rise) begin
                if (int'(r_extra) + EXTEND_STEP >= EXTRA_MAX) begin
                    r_extra <= EXTRA_MAX_T;
                end else begin
                    r_extra <= r_extra + STEP_T;
                end
            end
        end
    end

endmodule

// File: tb/tb_traffic_controller_nphase.sv
// Bench for traffic_controller_nphase. Expected per-cycle observations
// {lights, active_phase, phase_done} are queued before each scenario runs
// and popped and compared after every clock edge.
module tb_traffic_controller_nphase;

`ifdef TLC_DEMAND_SKIP_EN
    localparam int NP = 3;
`else
    localparam int NP = 2;
`endif
    localparam int AW = (NP > 1) ? $clog2(NP) : 1;
    localparam int W  = 3*NP + AW + 1;

    localparam int K_R    = 0;
    localparam int K_G    = 1;
    localparam int K_Y    = 2;
    localparam int K_FON  = 3;
    localparam int K_FOFF = 4;

    typedef logic [W-1:0] obs_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              tick = 1'b1;
    logic              preset = 1'b0;
    logic              preset_add = 1'b0;
    logic              preferential = 1'b0;
    logic              force_red = 1'b0;
    logic              attention = 1'b0;
    logic [NP-1:0]     phase_req = '0;
    logic [3*NP-1:0]   lights;
    logic [AW-1:0]     active_phase;
    logic              phase_done;

    int total = 0;
    int bad   = 0;
    obs_t exp_q[$];

    traffic_controller_nphase #(
        .NUM_PHASES(NP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .preset       (preset),
        .preset_add   (preset_add),
        .preferential (preferential),
        .force_red    (force_red),
        .attention    (attention),
        .phase_req    (phase_req),
        .lights       (lights),
        .active_phase (active_phase),
        .phase_done   (phase_done)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input int kind, input int ph, input bit done);
        logic [3*NP-1:0] l;
        l = '0;
        for (int p = 0; p < NP; p++) begin
            case (kind)
                K_G:     l[3*p +: 3] = (p == ph) ? 3'b100 : 3'b001;
                K_Y:     l[3*p +: 3] = (p == ph) ? 3'b010 : 3'b001;
                K_FON:   l[3*p +: 3] = 3'b010;
                K_FOFF:  l[3*p +: 3] = 3'b000;
                default: l[3*p +: 3] = 3'b001;
            endcase
        end
        return {l, AW'(ph), done};
    endfunction

    function automatic void push_n(input int n, input int kind, input int ph, input bit done);
        for (int i = 0; i < n; i++) exp_q.push_back(mk(kind, ph, done));
    endfunction

    // Full phase cycle with default timing: 30 green, 3 yellow, 2 all-red.
    function automatic void push_cycle(input int ph);
        push_n(30, K_G, ph, 1'b0);
        push_n(3,  K_Y, ph, 1'b0);
        push_n(1,  K_R, ph, 1'b1);
        push_n(1,  K_R, ph, 1'b0);
    endfunction

    task automatic do_reset(input bit pref, input bit pst, input logic [NP-1:0] req);
        rst = 1'b1;
        tick = 1'b1;
        preset = pst;
        preset_add = 1'b0;
        preferential = pref;
        force_red = 1'b0;
        attention = 1'b0;
        phase_req = req;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        obs_t got, ev;
        int n;
        rst = 1'b1;
        @(posedge clk); #1;
        got = {lights, active_phase, phase_done};
        ev = mk(K_R, 0, 1'b0);
        total++;
        if (got !== ev) begin
            bad++;
            $display("FAIL reset_state got=%h exp=%h", got, ev);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        push_n(5, K_G, 0, 1'b0);
        n = exp_q.size();
        for (int e = 1; e <= n; e++) begin
            @(posedge clk); #1;
            ev = exp_q.pop_front();
            got = {lights, active_phase, phase_done};
            total++;
            if (got !== ev) begin
                bad++;
                $display("FAIL reset_first_green e=%0d got=%h exp=%h", e, got, ev);
            end
        end
        // Asynchronous reset: outputs return to reset values without a clock edge.
        #2 rst = 1'b1;
        #1;
        got = {lights, active_phase, phase_done};
        ev = mk(K_R, 0, 1'b0);
        total++;
        if (got !== ev) begin
            bad++;
            $display("FAIL reset_async got=%h exp=%h", got, ev);
        end
    endtask

    task automatic test_basic;
        obs_t got, ev;
        int n;
        do_reset(1'b0, 1'b0, '0);
        push_cycle(0);
        push_cycle(1);
        push_n(5, K_G, 2 % NP, 1'b0);
        n = exp_q.size();
        for (int e = 1; e <= n; e++) begin
            @(posedge clk); #1;
            ev = exp_q.pop_front();
            got = {lights, active_phase, phase_done};
            total++;
            if (got !== ev) begin
                bad++;
                $display("FAIL basic_seq e=%0d got=%h exp=%h", e, got, ev);
            end
        end
    endtask

    task automatic test_preferential;
        obs_t got, ev;
        int n;
        do_reset(1'b1, 1'b0, '0);
        push_n(160, K_G, 0, 1'b0);
        push_n(12,  K_Y, 0, 1'b0);
        push_n(1,   K_R, 0, 1'b1);
        n = exp_q.size();
        for (int e = 1; e <= n; e++) begin
            tick = (e > 1) && ((e - 1) % 4 == 0);
            @(posedge clk); #1;
            ev = exp_q.pop_front();
            got = {lights, active_phase, phase_done};
            total++;
            if (got !== ev) begin
                bad++;
                $display("FAIL preferential e=%0d got=%h exp=%h", e, got, ev);
            end
        end
        tick = 1'b1;
    endtask

    task automatic test_preset;
        obs_t got, ev;
        int n;
        do_reset(1'b0, 1'b1, '0);
        push_n(13, K_R, 0, 1'b0);
        push_n(70, K_G, 0, 1'b0);
        push_n(3,  K_Y, 0, 1'b0);
        push_n(1,  K_R, 0, 1'b1);
        n = exp_q.size();
        for (int e = 1; e <= n; e++) begin
            preset = (e <= 13);
            preset_add = (e == 2) || (e == 4) || (e == 6) || (e >= 8 && e <= 12);
            @(posedge clk); #1;
            ev = exp_q.pop_front();
            got = {lights, active_phase, phase_done};
            total++;
            if (got !== ev) begin
                bad++;
                $display("FAIL preset_extend e=%0d got=%h exp=%h", e, got, ev);
            end
        end
        preset_add = 1'b0;
    endtask

    task automatic test_force_red;
        obs_t got, ev;
        int n;
        do_reset(1'b0, 1'b0, '0);
        push_n(11, K_G, 0, 1'b0);
        push_n(22, K_R, 0, 1'b0);
        push_n(5,  K_G, 1, 1'b0);
        n = exp_q.size();
        for (int e = 1; e <= n; e++) begin
            force_red = (e >= 12 && e <= 31);
            @(posedge clk); #1;
            ev = exp_q.pop_front();
            got = {lights, active_phase, phase_done};
            total++;
            if (got !== ev) begin
                bad++;
                $display("FAIL force_red e=%0d got=%h exp=%h", e, got, ev);
            end
        end
        force_red = 1'b0;
    endtask

    task automatic test_attention;
        obs_t got, ev;
        int n;
        do_reset(1'b0, 1'b0, '0);
        push_n(5, K_G, 0, 1'b0);
        push_n(3, K_Y, 0, 1'b0);
        push_n(1, K_FON, 0, 1'b1);
        push_n(1, K_FOFF, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            push_n(1, K_FON, 0, 1'b0);
            push_n(1, K_FOFF, 0, 1'b0);
        end
        push_n(2, K_R, 0, 1'b0);
        push_n(5, K_G, 1, 1'b0);
        n = exp_q.size();
        for (int e = 1; e <= n; e++) begin
            attention = (e >= 6 && e <= 18);
            @(posedge clk); #1;
            ev = exp_q.pop_front();
            got = {lights, active_phase, phase_done};
            total++;
            if (got !== ev) begin
                bad++;
                $display("FAIL attention e=%0d got=%h exp=%h", e, got, ev);
            end
        end
        attention = 1'b0;
    endtask

`ifdef TLC_DEMAND_SKIP_EN
    task automatic test_demand_skip;
        obs_t got, ev;
        int n;
        logic [NP-1:0] reqs [3];
        int            nxt  [3];
        reqs[0] = 3'b100; nxt[0] = 2;
        reqs[1] = 3'b000; nxt[1] = 1;
        reqs[2] = 3'b001; nxt[2] = 0;
        for (int t = 0; t < 3; t++) begin
            do_reset(1'b0, 1'b0, reqs[t]);
            push_cycle(0);
            push_n(3, K_G, nxt[t], 1'b0);
            n = exp_q.size();
            for (int e = 1; e <= n; e++) begin
                @(posedge clk); #1;
                ev = exp_q.pop_front();
                got = {lights, active_phase, phase_done};
                total++;
                if (got !== ev) begin
                    bad++;
                    $display("FAIL demand_skip req=%b e=%0d got=%h exp=%h", reqs[t], e, got, ev);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_preferential();
        test_preset();
        test_force_red();
        test_attention();
`ifdef TLC_DEMAND_SKIP_EN
        test_demand_skip();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/traffic_controller_nphase.md
Name: traffic_controller_nphase

Overview:
Parametrised N-phase intersection controller; successor to the single-approach light sequencer.
- Cycles NUM_PHASES approaches through green, yellow and all-red clearance.
- Preset/preferential green extension, force-red override and flashing-yellow attention mode.
- Counts time on an external tick enable, so one instance serves any timebase; sits between the timebase divider and the lamp drivers.

Parameters:
NUM_PHASES, 2, number of approaches (2..8)
TIMER_W, 8, width of timer and extra-time registers
GREEN_TIME, 30, base green duration in ticks
YELLOW_TIME, 3, yellow duration in ticks
ALLRED_TIME, 2, all-red clearance duration in ticks
EXTEND_STEP, 10, ticks added per preset_add press / by preferential
FLASH_HALF, 1, ticks per on/off half-period in FLASH

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
tick  in  1  timebase enable; timers advance only on cycles with tick=1
preset  in  1  hold in PRESET before first green
preset_add  in  1  each rising edge in PRESET adds EXTEND_STEP
preferential  in  1  sampled in INIT; 1 -> extra_time starts at EXTEND_STEP
force_red  in  1  level; all phases red while high
attention  in  1  level; request flashing-yellow mode
phase_req  in  NUM_PHASES  per-phase demand (used only with TLC_DEMAND_SKIP_EN)
lights  out  3*NUM_PHASES  phase p at [3p+2:3p] = {green,yellow,red}
active_phase  out  max(1,$clog2(NUM_PHASES))  phase currently served
phase_done  out  1  one-cycle pulse when a phase's yellow completes

Behaviour:
- Reset:
  - state=INIT, lights all 3'b001, active_phase=0, phase_done=0, timer=0, extra_time=0.
  - Reset asserted mid-operation: outputs go to reset values immediately.
- Registering: all outputs registered; lights/active_phase change on the same edge as the state register.
- States: INIT, PRESET, GREEN, YELLOW, ALLRED, FLASH, FORCED.
- INIT:
  - One cycle; extra_time = preferential ? EXTEND_STEP : 0.
  - Next state: PRESET if preset, else GREEN with phase 0.
- PRESET:
  - lights all red.
  - Each 0->1 of preset_add: extra_time += EXTEND_STEP, saturating at 2^TIMER_W-1-GREEN_TIME.
  - preset=0 -> GREEN, phase 0.
- Timer:
  - Cleared on every state entry.
  - On tick: if timer==dur-1, exit; else timer++.
  - A state therefore lasts exactly dur ticks; dur=0 is treated as 1.
- Durations: GREEN=GREEN_TIME+extra_time, YELLOW=YELLOW_TIME, ALLRED=ALLRED_TIME.
- GREEN / YELLOW lighting: active phase 3'b100 (GREEN) or 3'b010 (YELLOW); all others 3'b001.
- Sequence: GREEN expiry -> YELLOW. YELLOW expiry pulses phase_done, then -> ALLRED (or FLASH if attention=1).
- ALLRED:
  - All phases 001.
  - On expiry: active_phase = next phase (wraps NUM_PHASES-1 -> 0), -> GREEN.
- Priority each cycle: force_red > attention > timer expiry.
- force_red:
  - From GREEN/YELLOW/ALLRED/FLASH -> FORCED; lights all 001 on the next edge.
  - Ignored in INIT/PRESET.
  - Release -> ALLRED (full clearance), then next phase.
- attention:
  - In GREEN -> YELLOW (timer cleared), then FLASH on yellow expiry.
  - In YELLOW: completes yellow, then FLASH.
  - In ALLRED: -> FLASH immediately.
- FLASH:
  - All phases toggle 010 / 000 every FLASH_HALF ticks, starting at 010.
  - attention=0 -> ALLRED, then next phase.
- tick=0 freezes the timer only; force_red and attention still act on any cycle.

Optional Feature:
Macro TLC_DEMAND_SKIP_EN.
- Defined: at ALLRED expiry, next phase = first index after active_phase (round-robin, wrapping) with phase_req set. If no bit is set, advance by one as normal. The current phase is eligible only if it is the sole requester.
- Undefined: strict round-robin; phase_req ignored.

Test Plan:
1. Defaults, tick=1 every cycle, no inputs -> phase0 lights 100 for 30 cycles, 010 for 3, all 001 for 2, then phase1 100 for 30; phase_done pulses once per phase.
2. preferential=1 during INIT -> phase0 green lasts 40 ticks; tick every 4th cycle -> 160 cycles.
3. preset=1, three preset_add pulses, then a 5-cycle high hold (counts once), release preset -> green lasts 70 ticks.
4. force_red at green timer=10 -> next edge all 001; hold 20 cycles, release -> all-red 2 ticks, then phase1 green.
5. attention during green -> phase0 010 for 3 ticks, then all phases 010/000 alternating each tick; drop attention -> all-red 2 ticks, then phase1 green.
6. TLC_DEMAND_SKIP_EN, NUM_PHASES=3, phase_req=3'b100 -> after phase0 clearance phase2 goes green (phase1 skipped); phase_req=0 -> phase1 goes green.
